// File: rtl/inram_iter_ctrl.sv
// rtl/inram_iter_ctrl.sv - frame RAM fill / multi-pass read sequencer
//
// Purpose: accepts one frame of DEPTH symbols into the frame RAM, then
// replays the whole frame 1..4 times to a downstream decoder. Each pass
// starts only when the decoder reports rd_rdy. Once started, a pass always
// runs to the end. The frame can end early on abort.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cfg_iter[1:0]   read passes minus 1, latched at the first write of a frame
//   di_vld          input symbol present; accepted when in_rdy=1
//   in_rdy          block accepts input symbols (IDLE/FILL only)
//   ram_wea         frame RAM write enable
//   ram_addra       frame RAM write address
//   rd_rdy          decoder can take a full pass (sampled in WAIT only)
//   abort           early-termination request (ignored in IDLE/FILL)
//   ram_rd_en       frame RAM read strobe
//   ram_addrb       frame RAM read address
//   pass_idx[1:0]   current read pass index
//   pass_start      pulse with the first read of each pass
//   frame_done      pulse when the frame is finished
//   busy            high in every state except IDLE
//   ovf_err         pulse when di_vld arrives while in_rdy=0
module inram_iter_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_iter,
  input  logic          di_vld,
  output logic          in_rdy,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  input  logic          rd_rdy,
  input  logic          abort,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_addrb,
  output logic [1:0]    pass_idx,
  output logic          pass_start,
  output logic          frame_done,
  output logic          busy,
  output logic          ovf_err
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_READ, S_DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wcnt;      // address of the next accepted symbol
  logic [1:0]    npass;     // last pass index of the current frame
  logic          abort_l;   // abort seen during READ, honoured at pass end
  logic          accept;

  assign accept = di_vld & in_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      npass      <= '0;
      abort_l    <= 1'b0;
      in_rdy     <= 1'b1;
      ram_wea    <= 1'b0;
      ram_addra  <= '0;
      ram_rd_en  <= 1'b0;
      ram_addrb  <= '0;
      pass_idx   <= '0;
      pass_start <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      ram_wea    <= 1'b0;
      pass_start <= 1'b0;
      frame_done <= 1'b0;
      ovf_err    <= di_vld & ~in_rdy;

      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            ram_wea   <= 1'b1;
            ram_addra <= wcnt;
            busy      <= 1'b1;
            if (state == S_IDLE) npass <= cfg_iter;
            // wcnt parks on the last address instead of wrapping
            if (wcnt == LAST) begin
              in_rdy <= 1'b0;
              state  <= S_WAIT;
            end else begin
              wcnt  <= wcnt + 1'b1;
              state <= S_FILL;
            end
          end
        end

        S_WAIT: begin
          if (abort) begin
            abort_l    <= 1'b1;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else if (rd_rdy) begin
            ram_rd_en  <= 1'b1;
            ram_addrb  <= '0;
            pass_start <= 1'b1;
            state      <= S_READ;
          end
        end

        S_READ: begin
          if (abort) abort_l <= 1'b1;
          // ram_addrb doubles as the read counter for the running pass
          if (ram_addrb == LAST) begin
            ram_rd_en <= 1'b0;
            if (pass_idx == npass || abort_l || abort) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              pass_idx <= pass_idx + 1'b1;
              state    <= S_WAIT;
            end
          end else begin
            ram_addrb <= ram_addrb + 1'b1;
          end
        end

        S_DONE: begin
          pass_idx <= '0;
          abort_l  <= 1'b0;
          wcnt     <= '0;
          in_rdy   <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inram_iter_ctrl.sv
// tb/tb_inram_iter_ctrl.sv - directed self-checking bench for inram_iter_ctrl
module tb_inram_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_iter;
  logic       di_vld;
  logic       in_rdy;
  logic       ram_wea;
  logic [4:0] ram_addra;
  logic       rd_rdy;
  logic       abort;
  logic       ram_rd_en;
  logic [4:0] ram_addrb;
  logic [1:0] pass_idx;
  logic       pass_start;
  logic       frame_done;
  logic       busy;
  logic       ovf_err;

  int n_pass  = 0;
  int n_total = 0;

  inram_iter_ctrl #(.DEPTH(32), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_iter   (cfg_iter),
    .di_vld     (di_vld),
    .in_rdy     (in_rdy),
    .ram_wea    (ram_wea),
    .ram_addra  (ram_addra),
    .rd_rdy     (rd_rdy),
    .abort      (abort),
    .ram_rd_en  (ram_rd_en),
    .ram_addrb  (ram_addrb),
    .pass_idx   (pass_idx),
    .pass_start (pass_start),
    .frame_done (frame_done),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap=0: di_vld every cycle; gap=1: di_vld every other cycle
  task automatic do_fill(input int gap);
    int acc = 0;
    int cyc = 0;
    logic v;
    while (acc < 32) begin
      v = (gap == 0) || (cyc % 2 == 0);
      di_vld = v;
      tick();
      if (v) begin
        chk("fill_wea", ram_wea, 1);
        chk("fill_addra", ram_addra, acc);
        acc++;
      end else begin
        chk("gap_wea", ram_wea, 0);
        chk("gap_addra_hold", ram_addra, acc - 1);
      end
      chk("fill_in_rdy", in_rdy, (acc < 32) ? 1 : 0);
      chk("fill_busy", busy, 1);
      chk("fill_rd_en", ram_rd_en, 0);
      cyc++;
    end
    di_vld = 1'b0;
  endtask

  // Expects the first read on the next edge; abort is raised after read abort_at.
  task automatic do_pass(input int p, input int abort_at);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("rd_en", ram_rd_en, 1);
      chk("addrb", ram_addrb, i);
      chk("pass_idx", pass_idx, p);
      chk("pass_start", pass_start, (i == 0) ? 1 : 0);
      chk("rd_frame_done", frame_done, 0);
      chk("rd_wea", ram_wea, 0);
      abort = (i == abort_at);
    end
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_iter = 2'd0; di_vld = 1'b0; rd_rdy = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_wea", ram_wea, 0);
    chk("rst_addra", ram_addra, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_addrb", ram_addrb, 0);
    chk("rst_pass_idx", pass_idx, 0);
    chk("rst_pass_start", pass_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    rst = 1'b0;
    tick();

    // 4 passes, contiguous fill, rd_rdy held high
    cfg_iter = 2'd3; rd_rdy = 1'b1;
    do_fill(0);
    for (int p = 0; p < 4; p++) begin
      do_pass(p, -1);
      tick();
      chk("pass_end_rd_en", ram_rd_en, 0);
      if (p < 3) begin
        chk("gap_pass_idx", pass_idx, p + 1);
        chk("gap_frame_done", frame_done, 0);
      end else begin
        chk("f1_frame_done", frame_done, 1);
        chk("f1_busy_done", busy, 1);
      end
    end
    tick();
    chk("f1_idle_frame_done", frame_done, 0);
    chk("f1_idle_in_rdy", in_rdy, 1);
    chk("f1_idle_busy", busy, 0);
    chk("f1_idle_pass_idx", pass_idx, 0);

    // gapped fill, overflow in WAIT, rd_rdy late, cfg_iter change ignored
    cfg_iter = 2'd0; rd_rdy = 1'b0;
    do_fill(1);
    di_vld = 1'b1;
    tick();
    chk("ovf_pulse", ovf_err, 1);
    chk("ovf_no_wea", ram_wea, 0);
    chk("ovf_rd_en", ram_rd_en, 0);
    di_vld = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("wait_rd_en", ram_rd_en, 0);
      chk("wait_ovf", ovf_err, 0);
      chk("wait_addra_hold", ram_addra, 31);
    end
    cfg_iter = 2'd3; rd_rdy = 1'b1;
    do_pass(0, -1);
    tick();
    chk("f2_frame_done", frame_done, 1);
    chk("f2_pass_idx", pass_idx, 0);
    chk("f2_addrb_hold", ram_addrb, 31);
    tick();
    chk("f2_idle_in_rdy", in_rdy, 1);
    chk("f2_idle_frame_done", frame_done, 0);

    // abort mid pass 0 with 3 passes configured
    cfg_iter = 2'd2;
    do_fill(0);
    do_pass(0, 10);
    tick();
    chk("ab_frame_done", frame_done, 1);
    chk("ab_rd_en", ram_rd_en, 0);
    tick();
    chk("ab_idle_busy", busy, 0);
    tick();
    chk("ab_no_pass1", ram_rd_en, 0);
    chk("ab_no_pass_start", pass_start, 0);

    // reset during READ pass 1
    cfg_iter = 2'd1;
    do_fill(0);
    do_pass(0, -1);
    tick();
    tick();
    chk("pre_rst_pass_idx", pass_idx, 1);
    chk("pre_rst_rd_en", ram_rd_en, 1);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", ram_rd_en, 0);
    chk("mid_rst_addrb", ram_addrb, 0);
    chk("mid_rst_pass_idx", pass_idx, 0);
    chk("mid_rst_in_rdy", in_rdy, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_frame_done", frame_done, 0);
    // abort during FILL must not be latched
    abort = 1'b1;
    do_fill(0);
    abort = 1'b0;
    do_pass(0, -1);
    tick();
    chk("f4_gap_pass_idx", pass_idx, 1);
    chk("f4_gap_frame_done", frame_done, 0);
    do_pass(1, -1);
    tick();
    chk("f4_frame_done", frame_done, 1);
    tick();
    chk("f4_idle_in_rdy", in_rdy, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
